mem_port_arbiter: RTL

Two-master, single-slave memory arbiter for the single-cycle core. It shares one external memory bus between the instruction-cache refill port and the data-memory port. The refill port is driven by `i_cache` (req/addr/ready). The data port is driven by `d_mem` (rd/wr/addr/wd/byte_en/ready). Arbitration is fixed-priority with a starvation limit, plus a lock for atomic read-modify-write sequences.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master, single-slave memory bus arbiter: instruction-cache refill port vs data port.
// Fixed priority to data, bounded by a starvation limit, with a lock for atomic sequences.
`ifndef XLEN
`define XLEN 32
`endif

module mem_port_arbiter #(
  parameter int XLEN          = `XLEN,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ic_req,
  input  logic [XLEN-1:0] i_ic_addr,
  output logic [XLEN-1:0] o_ic_data,
  output logic            o_ic_ready,
  input  logic            i_dm_rd,
  input  logic            i_dm_wr,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wd,
  input  logic [3:0]      i_dm_byte_en,
  input  logic            i_dm_lock,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_dm_ready,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [XLEN-1:0] o_bus_wd,
  output logic [3:0]      o_bus_byte_en,
  input  logic [XLEN-1:0] i_bus_rdata,
  input  logic            i_bus_ack,
  output logic            o_grant_dm
);

  // Handshake: a requester holds its request until its one-cycle ready pulse,
  // and drops or replaces it on the edge that ends the ready cycle.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IC_BUSY = 3'd1,
    DM_BUSY = 3'd2,
    IC_RESP = 3'd3,
    DM_RESP = 3'd4
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  state_t     state;
  state_t     state_next;
  logic [3:0] streak;
  logic       locked;
  logic       dm_pend;
  logic       take_ic;
  logic       take_dm;

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_ic    = 1'b0;
    take_dm    = 1'b0;
    dm_pend    = i_dm_rd | i_dm_wr;
    case (state)
      IDLE: begin
        // Data wins unless the refill has waited out the full streak; a lock pins the bus to data.
        if (dm_pend && (locked || !i_ic_req || streak != STREAK_MAX)) begin
          take_dm    = 1'b1;
          state_next = DM_BUSY;
        end else if (i_ic_req && !locked) begin
          take_ic    = 1'b1;
          state_next = IC_BUSY;
        end
      end
      IC_BUSY: if (i_bus_ack) state_next = IC_RESP;
      DM_BUSY: if (i_bus_ack) state_next = DM_RESP;
      IC_RESP: state_next = IDLE;
      DM_RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      streak        <= 4'd0;
      locked        <= 1'b0;
      o_bus_req     <= 1'b0;
      o_bus_we      <= 1'b0;
      o_bus_addr    <= '0;
      o_bus_wd      <= '0;
      o_bus_byte_en <= 4'b0000;
      o_ic_ready    <= 1'b0;
      o_ic_data     <= '0;
      o_dm_ready    <= 1'b0;
      o_dm_rdata    <= '0;
      o_grant_dm    <= 1'b0;
    end else begin
      o_ic_ready <= 1'b0;
      o_dm_ready <= 1'b0;

      if (take_ic) begin
        o_bus_req     <= 1'b1;
        o_bus_we      <= 1'b0;
        o_bus_addr    <= i_ic_addr;
        o_bus_wd      <= '0;
        o_bus_byte_en <= 4'b1111;
        streak        <= 4'd0;
        o_grant_dm    <= 1'b0;
      end

      if (take_dm) begin
        o_bus_req     <= 1'b1;
        o_bus_we      <= i_dm_wr;
        o_bus_addr    <= i_dm_addr;
        o_bus_wd      <= i_dm_wd;
        o_bus_byte_en <= i_dm_byte_en;
        locked        <= i_dm_lock;
        o_grant_dm    <= 1'b1;
        if (i_ic_req && streak < STREAK_MAX) streak <= streak + 4'd1;
      end

      if (i_bus_ack && state == IC_BUSY) begin
        o_bus_req  <= 1'b0;
        o_ic_ready <= 1'b1;
        o_ic_data  <= i_bus_rdata;
      end

      if (i_bus_ack && state == DM_BUSY) begin
        o_bus_req  <= 1'b0;
        o_dm_ready <= 1'b1;
        if (!o_bus_we) o_dm_rdata <= i_bus_rdata;
      end
    end
  end

endmodule
